// File: rtl/bp_be_mem_misalign_split_pkg.sv
// Shared types for the BE memory misalignment splitter.
//   bp_be_misalign_state_e : splitter FSM states
//   bp_be_mem_size_e       : log2 access size encoding (byte/half/word/dword)
//   size_bytes()           : number of bytes touched by an access size
package bp_be_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_send_lo,
    e_wait_lo,
    e_send_hi,
    e_wait_hi,
    e_resp,
    e_drain
  } bp_be_misalign_state_e;

  typedef enum logic [1:0] {
    e_size_b,
    e_size_h,
    e_size_w,
    e_size_d
  } bp_be_mem_size_e;

  function automatic int unsigned size_bytes(input bp_be_mem_size_e size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/bp_be_mem_misalign_split_if.sv
// Bundle of every signal between the BE memory pipe / D$ and the splitter.
//   slave  : the splitter (takes requests, drives D$ packets and completions)
//   master : the environment (issues requests, models the D$)
// Request side : flush_i, req_v_i/req_ready_o, req_vaddr_i, req_size_i,
//                req_store_i, req_signed_i, req_data_i
// D$ side      : dc_v_o/dc_ready_i, dc_vaddr_o, dc_store_o, dc_mask_o,
//                dc_data_o, dc_resp_v_i, dc_resp_data_i
// Completion   : resp_v_o, resp_data_o, misaligned_v_o, split_v_o
interface bp_be_mem_misalign_split_if #(
  parameter int vaddr_width_p = 39,
  parameter int dword_width_p = 64
);

  logic                         flush_i;
  logic                         req_v_i;
  logic                         req_ready_o;
  logic [vaddr_width_p-1:0]     req_vaddr_i;
  logic [1:0]                   req_size_i;
  logic                         req_store_i;
  logic                         req_signed_i;
  logic [dword_width_p-1:0]     req_data_i;

  logic                         dc_v_o;
  logic                         dc_ready_i;
  logic [vaddr_width_p-1:0]     dc_vaddr_o;
  logic                         dc_store_o;
  logic [dword_width_p/8-1:0]   dc_mask_o;
  logic [dword_width_p-1:0]     dc_data_o;
  logic                         dc_resp_v_i;
  logic [dword_width_p-1:0]     dc_resp_data_i;

  logic                         resp_v_o;
  logic [dword_width_p-1:0]     resp_data_o;
  logic                         misaligned_v_o;
  logic                         split_v_o;

  modport slave (
    input  flush_i, req_v_i, req_vaddr_i, req_size_i, req_store_i,
           req_signed_i, req_data_i, dc_ready_i, dc_resp_v_i, dc_resp_data_i,
    output req_ready_o, dc_v_o, dc_vaddr_o, dc_store_o, dc_mask_o, dc_data_o,
           resp_v_o, resp_data_o, misaligned_v_o, split_v_o
  );

  modport master (
    output flush_i, req_v_i, req_vaddr_i, req_size_i, req_store_i,
           req_signed_i, req_data_i, dc_ready_i, dc_resp_v_i, dc_resp_data_i,
    input  req_ready_o, dc_v_o, dc_vaddr_o, dc_store_o, dc_mask_o, dc_data_o,
           resp_v_o, resp_data_o, misaligned_v_o, split_v_o
  );

endinterface

// File: rtl/bp_be_mem_misalign_split_lane_align.sv
// Combinational byte-lane aligner over a two-dword window.
//   load_p = 0 (store direction): result = (low size bytes of src) << 8*off,
//                                 i.e. {hi, lo} lane-aligned store data.
//   load_p = 1 (load direction) : result low dword = ({hi, lo} >> 8*off)
//                                 truncated to size bytes and sign/zero
//                                 extended; upper dword is zero.
//   mask : byte enables of the access over both dwords, (ones(n) << off).
// Ports: off (byte offset in dword), size, sign_ext, src, result, mask.
module bp_be_mem_lane_align
  import bp_be_pkg::*;
#(
  parameter int dword_width_p = 64,
  parameter bit load_p        = 1'b0
) (
  input  logic [$clog2(dword_width_p/8)-1:0] off,
  input  bp_be_mem_size_e                    size,
  input  logic                               sign_ext,
  input  logic [2*dword_width_p-1:0]         src,
  output logic [2*dword_width_p-1:0]         result,
  output logic [dword_width_p/4-1:0]         mask
);

  localparam int w_lp    = dword_width_p;
  localparam int w2_lp   = 2 * dword_width_p;
  localparam int b2_lp   = dword_width_p / 4;
  localparam int lg_b_lp = $clog2(dword_width_p / 8);

  // All-ones over the low n bytes of a two-dword value.
  function automatic logic [w2_lp-1:0] byte_ones(input int n);
    logic [w2_lp-1:0] r;
    r = '0;
    for (int i = 0; i < w2_lp / 8; i++) begin
      if (i < n) r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  // Keep the low n bytes of v, then fill above them with the top kept bit
  // when sign extension is requested.
  function automatic logic [w_lp-1:0] extend(input logic [w_lp-1:0] v,
                                             input int n,
                                             input logic sgn_req);
    logic [w2_lp-1:0] ones;
    logic [w_lp-1:0]  keep;
    logic [w_lp-1:0]  top;
    logic [w_lp-1:0]  r;
    ones = byte_ones(n);
    keep = ones[w_lp-1:0];
    top  = v >> (8 * n - 1);
    r    = v & keep;
    if (sgn_req && top[0]) r = r | ~keep;
    return r;
  endfunction

  int n;
  logic [lg_b_lp+2:0] shamt;

  assign n     = int'(size_bytes(size));
  assign shamt = {off, 3'b000};

  always_comb begin
    mask = '0;
    for (int i = 0; i < b2_lp; i++) begin
      mask[i] = (i >= int'(off)) && (i < int'(off) + n);
    end
  end

  if (load_p) begin : g_load
    logic [w2_lp-1:0] shr;
    assign shr    = src >> shamt;
    assign result = {{w_lp{1'b0}}, extend(shr[w_lp-1:0], n, sign_ext)};
  end else begin : g_store
    logic unused_sign_ext;
    assign unused_sign_ext = sign_ext;
    // Bytes above the access size are dropped so unmasked lanes carry zero.
    assign result = (src & byte_ones(n)) << shamt;
  end

endmodule

// File: rtl/bp_be_mem_misalign_split.sv
// Splits arbitrary-size integer loads/stores from the BE memory pipe into
// one or two aligned dword D$ accesses, merges/extends split load data and
// reports page-crossing (or, with splitting disabled, any misaligned)
// accesses as misaligned faults without touching the D$.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   io (slave)     : request, D$ packet/response and completion signals
module bp_be_mem_misalign_split
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p        = 39,
  parameter int dword_width_p        = 64,
  parameter int page_offset_width_p  = 12,
  parameter bit support_misaligned_p = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  bp_be_mem_misalign_split_if.slave  io
);

  localparam int b_lp    = dword_width_p / 8;
  localparam int lg_b_lp = $clog2(b_lp);
  localparam int w_lp    = dword_width_p;
  localparam int w2_lp   = 2 * dword_width_p;

  bp_be_misalign_state_e state_r, state_n;

  logic [vaddr_width_p-1:0] vaddr_p0;
  bp_be_mem_size_e          size_p0;
  logic                     store_p0;
  logic                     sign_p0;
  logic                     cross_p0;
  logic                     fault_p0;
  logic [w_lp-1:0]          data_p0;
  logic [w_lp-1:0]          lo_resp_p1;
  logic [w_lp-1:0]          hi_resp_p1;

  logic accept, cap_lo, cap_hi;

  // Address decode of the incoming request
  logic [lg_b_lp-1:0] off_in;
  logic [lg_b_lp-1:0] nmask_in;
  logic [lg_b_lp:0]   nbytes_in;
  logic               mis_in, cross_in, pgx_in, fault_in;

  assign off_in    = io.req_vaddr_i[lg_b_lp-1:0];
  assign nbytes_in = (lg_b_lp+1)'(size_bytes(bp_be_mem_size_e'(io.req_size_i)));
  assign nmask_in  = lg_b_lp'(nbytes_in - (lg_b_lp+1)'(1));
  assign mis_in    = (off_in & nmask_in) != '0;
  assign cross_in  = ({1'b0, off_in} + nbytes_in) > (lg_b_lp+1)'(b_lp);
  // Crossing out of the last dword of a page would need a second translation.
  assign pgx_in    = cross_in & (&io.req_vaddr_i[page_offset_width_p-1:lg_b_lp]);
  assign fault_in  = pgx_in | (mis_in & !support_misaligned_p);

  assign io.req_ready_o = (state_r == e_idle) & ~io.flush_i;
  assign accept         = io.req_v_i & io.req_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      vaddr_p0   <= '0;
      size_p0    <= e_size_b;
      store_p0   <= 1'b0;
      sign_p0    <= 1'b0;
      cross_p0   <= 1'b0;
      fault_p0   <= 1'b0;
      data_p0    <= '0;
      lo_resp_p1 <= '0;
      hi_resp_p1 <= '0;
    end else begin
      state_r <= state_n;
      // p0: request capture
      if (accept) begin
        vaddr_p0   <= io.req_vaddr_i;
        size_p0    <= bp_be_mem_size_e'(io.req_size_i);
        store_p0   <= io.req_store_i;
        sign_p0    <= io.req_signed_i;
        cross_p0   <= cross_in;
        fault_p0   <= fault_in;
        data_p0    <= io.req_data_i;
        lo_resp_p1 <= '0;
        hi_resp_p1 <= '0;
      end
      // p1: D$ response capture
      if (cap_lo) lo_resp_p1 <= io.dc_resp_data_i;
      if (cap_hi) hi_resp_p1 <= io.dc_resp_data_i;
    end
  end

  always_comb begin
    state_n = state_r;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    unique case (state_r)
      e_idle: begin
        if (accept) state_n = fault_in ? e_resp : e_send_lo;
      end
      e_send_lo: begin
        if (io.flush_i)         state_n = e_idle;
        else if (io.dc_ready_i) state_n = e_wait_lo;
      end
      e_wait_lo: begin
        // A response arriving with the flush settles the access outright.
        if (io.flush_i) begin
          state_n = io.dc_resp_v_i ? e_idle : e_drain;
        end else if (io.dc_resp_v_i) begin
          cap_lo  = 1'b1;
          state_n = cross_p0 ? e_send_hi : e_resp;
        end
      end
      e_send_hi: begin
        if (io.flush_i)         state_n = e_idle;
        else if (io.dc_ready_i) state_n = e_wait_hi;
      end
      e_wait_hi: begin
        if (io.flush_i) begin
          state_n = io.dc_resp_v_i ? e_idle : e_drain;
        end else if (io.dc_resp_v_i) begin
          cap_hi  = 1'b1;
          state_n = e_resp;
        end
      end
      e_resp:  state_n = e_idle;
      e_drain: begin
        if (io.dc_resp_v_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // Lane alignment: store shift/mask from the registered request, load
  // merge/extension from the captured response dwords.
  logic [w2_lp-1:0]  st_data, ld_data;
  logic [2*b_lp-1:0] st_mask, ld_mask;

  bp_be_mem_lane_align #(
    .dword_width_p (dword_width_p),
    .load_p        (1'b0)
  ) store_align (
    .off      (vaddr_p0[lg_b_lp-1:0]),
    .size     (size_p0),
    .sign_ext (sign_p0),
    .src      ({{w_lp{1'b0}}, data_p0}),
    .result   (st_data),
    .mask     (st_mask)
  );

  bp_be_mem_lane_align #(
    .dword_width_p (dword_width_p),
    .load_p        (1'b1)
  ) load_align (
    .off      (vaddr_p0[lg_b_lp-1:0]),
    .size     (size_p0),
    .sign_ext (sign_p0),
    .src      ({hi_resp_p1, lo_resp_p1}),
    .result   (ld_data),
    .mask     (ld_mask)
  );

  logic unused_load_bits;
  assign unused_load_bits = ^{ld_data[w2_lp-1:w_lp], ld_mask};

  logic [vaddr_width_p-1:0] lo_addr, hi_addr;
  logic                     send_st, hi_phase, resp_st;

  assign lo_addr  = {vaddr_p0[vaddr_width_p-1:lg_b_lp], {lg_b_lp{1'b0}}};
  assign hi_addr  = lo_addr + vaddr_width_p'(b_lp);
  assign send_st  = (state_r == e_send_lo) || (state_r == e_send_hi);
  assign hi_phase = (state_r == e_send_hi);
  assign resp_st  = (state_r == e_resp);

  // Packet fields are held at zero whenever no access is being offered.
  assign io.dc_v_o     = send_st & ~io.flush_i;
  assign io.dc_vaddr_o = io.dc_v_o ? (hi_phase ? hi_addr : lo_addr) : '0;
  assign io.dc_store_o = io.dc_v_o & store_p0;
  assign io.dc_mask_o  = io.dc_v_o ? (hi_phase ? st_mask[2*b_lp-1:b_lp] : st_mask[b_lp-1:0]) : '0;
  assign io.dc_data_o  = io.dc_v_o ? (hi_phase ? st_data[w2_lp-1:w_lp] : st_data[w_lp-1:0]) : '0;

  assign io.resp_v_o       = resp_st & ~io.flush_i;
  assign io.resp_data_o    = (io.resp_v_o & ~store_p0 & ~fault_p0) ? ld_data[w_lp-1:0] : '0;
  assign io.misaligned_v_o = io.resp_v_o & fault_p0;
  assign io.split_v_o      = io.resp_v_o & cross_p0 & ~fault_p0;

endmodule

// File: tb/tb_bp_be_mem_misalign_split.sv
module tb_bp_be_mem_misalign_split;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_be_mem_misalign_split_if #(.vaddr_width_p(39), .dword_width_p(64)) ifa ();
  bp_be_mem_misalign_split_if #(.vaddr_width_p(39), .dword_width_p(64)) ifb ();

  bp_be_mem_misalign_split #(
    .vaddr_width_p(39), .dword_width_p(64), .page_offset_width_p(12),
    .support_misaligned_p(1'b1)
  ) dut_a (.clk_i(clk), .reset_i(rst), .io(ifa));

  bp_be_mem_misalign_split #(
    .vaddr_width_p(39), .dword_width_p(64), .page_offset_width_p(12),
    .support_misaligned_p(1'b0)
  ) dut_b (.clk_i(clk), .reset_i(rst), .io(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request on dut_a in the current (idle) cycle; returns in the
  // cycle after acceptance with req_v_i dropped.
  task automatic issue_a(input logic [38:0] vaddr, input logic [1:0] size,
                         input logic store, input logic sgn, input logic [63:0] data);
    ifa.req_v_i      = 1'b1;
    ifa.req_vaddr_i  = vaddr;
    ifa.req_size_i   = size;
    ifa.req_store_i  = store;
    ifa.req_signed_i = sgn;
    ifa.req_data_i   = data;
    #1;
    chk("req_ready_idle", 64'(ifa.req_ready_o), 64'd1);
    tick();
    ifa.req_v_i    = 1'b0;
    ifa.req_data_i = '0;
  endtask

  // Check the D$ packet offered this cycle, then return the response one
  // cycle later; ends in the cycle after the response.
  task automatic access_a(input string tag, input logic [38:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic store, input logic [63:0] rdata);
    #1;
    chk({tag, "_dc_v"},     64'(ifa.dc_v_o), 64'd1);
    chk({tag, "_dc_addr"},  64'(ifa.dc_vaddr_o), 64'(addr));
    chk({tag, "_dc_mask"},  64'(ifa.dc_mask_o), 64'(mask));
    chk({tag, "_dc_data"},  ifa.dc_data_o, data);
    chk({tag, "_dc_store"}, 64'(ifa.dc_store_o), 64'(store));
    tick();
    ifa.dc_resp_v_i    = 1'b1;
    ifa.dc_resp_data_i = rdata;
    #1;
    chk({tag, "_no_resp_wait"}, 64'(ifa.resp_v_o), 64'd0);
    tick();
    ifa.dc_resp_v_i    = 1'b0;
    ifa.dc_resp_data_i = '0;
  endtask

  // Expect the completion pulse this cycle and idle the cycle after.
  task automatic resp_a(input string tag, input logic [63:0] data,
                        input logic mis, input logic split);
    #1;
    chk({tag, "_resp_v"},   64'(ifa.resp_v_o), 64'd1);
    chk({tag, "_resp_data"}, ifa.resp_data_o, data);
    chk({tag, "_mis"},      64'(ifa.misaligned_v_o), 64'(mis));
    chk({tag, "_split"},    64'(ifa.split_v_o), 64'(split));
    chk({tag, "_ready_resp"}, 64'(ifa.req_ready_o), 64'd0);
    chk({tag, "_dc_v_resp"},  64'(ifa.dc_v_o), 64'd0);
    tick();
    #1;
    chk({tag, "_resp_pulse"}, 64'(ifa.resp_v_o), 64'd0);
    chk({tag, "_ready_back"}, 64'(ifa.req_ready_o), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    ifa.flush_i = 1'b0; ifa.req_v_i = 1'b0; ifa.req_vaddr_i = '0; ifa.req_size_i = '0;
    ifa.req_store_i = 1'b0; ifa.req_signed_i = 1'b0; ifa.req_data_i = '0;
    ifa.dc_ready_i = 1'b1; ifa.dc_resp_v_i = 1'b0; ifa.dc_resp_data_i = '0;
    ifb.flush_i = 1'b0; ifb.req_v_i = 1'b0; ifb.req_vaddr_i = '0; ifb.req_size_i = '0;
    ifb.req_store_i = 1'b0; ifb.req_signed_i = 1'b0; ifb.req_data_i = '0;
    ifb.dc_ready_i = 1'b1; ifb.dc_resp_v_i = 1'b0; ifb.dc_resp_data_i = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready",     64'(ifa.req_ready_o), 64'd1);
    chk("rst_dc_v",      64'(ifa.dc_v_o), 64'd0);
    chk("rst_resp_v",    64'(ifa.resp_v_o), 64'd0);
    chk("rst_mis",       64'(ifa.misaligned_v_o), 64'd0);
    chk("rst_split",     64'(ifa.split_v_o), 64'd0);
    chk("rst_resp_data", ifa.resp_data_o, 64'd0);
    chk("rst_dc_mask",   64'(ifa.dc_mask_o), 64'd0);
    chk("rst_b_ready",   64'(ifb.req_ready_o), 64'd1);
    tick();

    // Aligned ld: response at N+3
    issue_a(39'h1000, 2'd3, 1'b0, 1'b0, 64'd0);
    access_a("ld", 39'h1000, 8'hFF, 64'd0, 1'b0, 64'h0123456789ABCDEF);
    resp_a("ld", 64'h0123456789ABCDEF, 1'b0, 1'b0);

    // Signed split lw: response at N+5
    issue_a(39'h1006, 2'd2, 1'b0, 1'b1, 64'd0);
    access_a("lw_lo", 39'h1000, 8'hC0, 64'd0, 1'b0, 64'h1234_0000_0000_0000);
    access_a("lw_hi", 39'h1008, 8'h03, 64'd0, 1'b0, 64'h0000_0000_0000_9678);
    resp_a("lw", 64'hFFFF_FFFF_9678_1234, 1'b0, 1'b1);

    // Split sd; store completions carry zero data whatever the D$ returns
    issue_a(39'h1003, 2'd3, 1'b1, 1'b0, 64'h1122334455667788);
    access_a("sd_lo", 39'h1000, 8'hF8, 64'h4455667788000000, 1'b1, 64'hDEADBEEFDEADBEEF);
    access_a("sd_hi", 39'h1008, 8'h07, 64'h0000000000112233, 1'b1, 64'hDEADBEEFDEADBEEF);
    resp_a("sd", 64'd0, 1'b0, 1'b1);

    // sw: upper request bits must not leak into unmasked lanes
    issue_a(39'h1004, 2'd2, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D);
    access_a("sw", 39'h1000, 8'hF0, 64'hCAFEF00D_00000000, 1'b1, 64'd0);
    resp_a("sw", 64'd0, 1'b0, 1'b0);

    // Signed lb in the top lane
    issue_a(39'h1007, 2'd0, 1'b0, 1'b1, 64'd0);
    access_a("lb", 39'h1000, 8'h80, 64'd0, 1'b0, 64'h81AA_0000_0000_0000);
    resp_a("lb", 64'hFFFF_FFFF_FFFF_FF81, 1'b0, 1'b0);

    // Misaligned lhu inside one dword: single access, zero-extended
    issue_a(39'h1001, 2'd1, 1'b0, 1'b0, 64'd0);
    access_a("lhu", 39'h1000, 8'h06, 64'd0, 1'b0, 64'hFFFF_FFFF_FFBE_EFFF);
    resp_a("lhu", 64'h0000_0000_0000_BEEF, 1'b0, 1'b0);

    // Page-crossing lh: fault at N+1, no D$ access
    issue_a(39'h1FFF, 2'd1, 1'b0, 1'b0, 64'd0);
    resp_a("pgx", 64'd0, 1'b1, 1'b0);

    // Flush while the high half of a split lw is outstanding
    issue_a(39'h1006, 2'd2, 1'b0, 1'b1, 64'd0);
    access_a("fl_lo", 39'h1000, 8'hC0, 64'd0, 1'b0, 64'h1234_0000_0000_0000);
    #1;
    chk("fl_send_hi_dc_v", 64'(ifa.dc_v_o), 64'd1);
    chk("fl_send_hi_addr", 64'(ifa.dc_vaddr_o), 64'h1008);
    tick();
    ifa.flush_i = 1'b1;
    #1;
    chk("fl_wait_resp_v", 64'(ifa.resp_v_o), 64'd0);
    chk("fl_wait_ready",  64'(ifa.req_ready_o), 64'd0);
    tick();
    ifa.flush_i        = 1'b0;
    ifa.dc_resp_v_i    = 1'b1;
    ifa.dc_resp_data_i = 64'h9678;
    #1;
    chk("fl_drain_ready",  64'(ifa.req_ready_o), 64'd0);
    chk("fl_drain_resp_v", 64'(ifa.resp_v_o), 64'd0);
    chk("fl_drain_dc_v",   64'(ifa.dc_v_o), 64'd0);
    tick();
    ifa.dc_resp_v_i    = 1'b0;
    ifa.dc_resp_data_i = '0;
    #1;
    chk("fl_idle_ready",  64'(ifa.req_ready_o), 64'd1);
    chk("fl_idle_resp_v", 64'(ifa.resp_v_o), 64'd0);
    issue_a(39'h2000, 2'd3, 1'b0, 1'b0, 64'd0);
    access_a("ld2", 39'h2000, 8'hFF, 64'd0, 1'b0, 64'hCAFEBABEDEADBEEF);
    resp_a("ld2", 64'hCAFEBABEDEADBEEF, 1'b0, 1'b0);

    // Flush in e_send_lo with dc_ready_i high: no handshake, back to idle
    issue_a(39'h3000, 2'd3, 1'b0, 1'b0, 64'd0);
    ifa.flush_i = 1'b1;
    #1;
    chk("fl_send_dc_v", 64'(ifa.dc_v_o), 64'd0);
    tick();
    ifa.flush_i = 1'b0;
    #1;
    chk("fl_send_ready",  64'(ifa.req_ready_o), 64'd1);
    chk("fl_send_dc_v2",  64'(ifa.dc_v_o), 64'd0);
    chk("fl_send_resp_v", 64'(ifa.resp_v_o), 64'd0);

    // Splitting disabled: misaligned lw faults, aligned lw proceeds
    ifb.req_v_i = 1'b1; ifb.req_vaddr_i = 39'h1002; ifb.req_size_i = 2'd2;
    ifb.req_store_i = 1'b0; ifb.req_signed_i = 1'b0;
    #1;
    chk("b_mis_ready", 64'(ifb.req_ready_o), 64'd1);
    tick();
    ifb.req_v_i = 1'b0;
    #1;
    chk("b_mis_resp_v", 64'(ifb.resp_v_o), 64'd1);
    chk("b_mis_fault",  64'(ifb.misaligned_v_o), 64'd1);
    chk("b_mis_dc_v",   64'(ifb.dc_v_o), 64'd0);
    tick();
    ifb.req_v_i = 1'b1; ifb.req_vaddr_i = 39'h1004; ifb.req_size_i = 2'd2;
    #1;
    chk("b_mis_pulse", 64'(ifb.resp_v_o), 64'd0);
    tick();
    ifb.req_v_i = 1'b0;
    #1;
    chk("b_lw_dc_v",    64'(ifb.dc_v_o), 64'd1);
    chk("b_lw_dc_addr", 64'(ifb.dc_vaddr_o), 64'h1000);
    chk("b_lw_dc_mask", 64'(ifb.dc_mask_o), 64'hF0);
    tick();
    ifb.dc_resp_v_i = 1'b1; ifb.dc_resp_data_i = 64'h89ABCDEF_00000000;
    tick();
    ifb.dc_resp_v_i = 1'b0; ifb.dc_resp_data_i = '0;
    #1;
    chk("b_lw_resp_v",    64'(ifb.resp_v_o), 64'd1);
    chk("b_lw_resp_data", ifb.resp_data_o, 64'h0000_0000_89AB_CDEF);
    chk("b_lw_mis",       64'(ifb.misaligned_v_o), 64'd0);
    chk("b_lw_split",     64'(ifb.split_v_o), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
